// File: rtl/div_ctrl.sv
// Request-side controller for the iterative radix-2 divider: operand prep, start pulse, result fix-up.
// Latency: accept to resp_valid is 2 cycles plus the divider run time; special cases take 1 cycle with DIV_FASTPATH_EN.
// Backpressure: one operation in flight; req_ready only in IDLE, RESP holds until resp_ready or flush.
// Optional feature macro: DIV_FASTPATH_EN (divide-by-zero / signed overflow bypass the divider).
module div_ctrl #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic             req_w,
    input  logic [63:0]      req_a,
    input  logic [63:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [63:0]      resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic             div_valid,
    output logic             div_sign,
    output logic             div_w,
    output logic [63:0]      div_dividend,
    output logic [63:0]      div_divisor,
    input  logic [63:0]      div_quotient,
    input  logic [63:0]      div_remainder,
    input  logic             div_out_valid
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        DRAIN = 3'd3,
        RESP  = 3'd4
    } state_t;

    localparam logic [63:0] INT64_MIN = 64'h8000_0000_0000_0000;

    // Divisor zero at the effective width (low word only for W-forms).
    function automatic logic is_div_zero(input logic w, input logic [63:0] b);
        return w ? (b[31:0] == 32'd0) : (b == 64'd0);
    endfunction

    // Most-negative / -1 at the effective width; only meaningful for signed ops.
    function automatic logic is_overflow(input logic sgn, input logic w,
                                         input logic [63:0] a, input logic [63:0] b);
        if (!sgn)
            return 1'b0;
        if (w)
            return (a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF);
        return (a == INT64_MIN) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
    endfunction

    // Apply RISC-V special-case results over the divider output, pick q/r, sign-extend W-forms.
    function automatic logic [63:0] final_result(input logic [1:0]  op, input logic w,
                                                 input logic [63:0] a,  input logic [63:0] b,
                                                 input logic [63:0] q,  input logic [63:0] r);
        logic [63:0] q_eff;
        logic [63:0] r_eff;
        logic [63:0] sel;
        q_eff = q;
        r_eff = r;
        if (is_div_zero(w, b)) begin
            q_eff = 64'hFFFF_FFFF_FFFF_FFFF;
            r_eff = a;
        end else if (is_overflow(!op[0], w, a, b)) begin
            q_eff = a;
            r_eff = 64'd0;
        end
        sel = op[1] ? r_eff : q_eff;
        return w ? {{32{sel[31]}}, sel[31:0]} : sel;
    endfunction

    state_t             state_q, state_d;
    logic [1:0]         op_q;
    logic               w_q;
    logic               sign_q;
    logic               divw_q;
    logic [63:0]        dvd_q;
    logic [63:0]        dvs_q;
    logic [63:0]        data_q;
    logic [TAG_W-1:0]   tag_q;

    logic               req_sgn;
    logic [63:0]        prep_a;
    logic [63:0]        prep_b;
    logic               accept;
    logic               capture;
    logic               fast_path;

    // Even op codes (DIV, REM) are signed; unsigned W-forms feed the divider zero-extended low words.
    assign req_sgn = ~req_op[0];
    assign prep_a  = (req_w && !req_sgn) ? {32'd0, req_a[31:0]} : req_a;
    assign prep_b  = (req_w && !req_sgn) ? {32'd0, req_b[31:0]} : req_b;
    assign accept  = (state_q == IDLE) && req_valid && !flush;
    assign capture = (state_q == WAIT) && div_out_valid && !flush;

`ifdef DIV_FASTPATH_EN
    assign fast_path = is_div_zero(req_w, prep_b) || is_overflow(req_sgn, req_w, prep_a, prep_b);
`else
    assign fast_path = 1'b0;
`endif

    // State register; reset drops any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic. A started divide always runs to completion, so a flush before
    // the result arrives parks in DRAIN to swallow the completion pulse.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (accept) state_d = fast_path ? RESP : ISSUE;
            ISSUE: state_d = flush ? DRAIN : WAIT;
            WAIT: begin
                if (flush)
                    state_d = div_out_valid ? IDLE : DRAIN;
                else if (div_out_valid)
                    state_d = RESP;
            end
            DRAIN: if (div_out_valid) state_d = IDLE;
            RESP:  if (flush || resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request capture on accept and result capture on divider completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= 2'd0;
            w_q    <= 1'b0;
            sign_q <= 1'b0;
            divw_q <= 1'b0;
            dvd_q  <= 64'd0;
            dvs_q  <= 64'd0;
            data_q <= 64'd0;
            tag_q  <= '0;
        end else if (accept) begin
            op_q   <= req_op;
            w_q    <= req_w;
            sign_q <= req_sgn;
            divw_q <= req_w & req_sgn;
            dvd_q  <= prep_a;
            dvs_q  <= prep_b;
            tag_q  <= req_tag;
            if (fast_path)
                data_q <= final_result(req_op, req_w, prep_a, prep_b, 64'd0, 64'd0);
        end else if (capture) begin
            data_q <= final_result(op_q, w_q, dvd_q, dvs_q, div_quotient, div_remainder);
        end
    end

    assign req_ready    = (state_q == IDLE);
    assign resp_valid   = (state_q == RESP);
    assign resp_data    = data_q;
    assign resp_tag     = tag_q;
    assign div_valid    = (state_q == ISSUE);
    assign div_sign     = sign_q;
    assign div_w        = divw_q;
    assign div_dividend = dvd_q;
    assign div_divisor  = dvs_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: fixed vectors, flush/stall/reset sequences and random ops vs a reference model.
// Latency expectations follow the build: special cases take 1 cycle only with DIV_FASTPATH_EN.
// A behavioural divider answers each start pulse 65 cycles later.
module tb_div_ctrl;

    localparam int TAG_W = 5;

    logic             clk;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic             req_w;
    logic [63:0]      req_a;
    logic [63:0]      req_b;
    logic [TAG_W-1:0] req_tag;
    logic             flush;
    logic             resp_valid;
    logic             resp_ready;
    logic [63:0]      resp_data;
    logic [TAG_W-1:0] resp_tag;
    logic             div_valid;
    logic             div_sign;
    logic             div_w;
    logic [63:0]      div_dividend;
    logic [63:0]      div_divisor;
    logic [63:0]      div_quotient;
    logic [63:0]      div_remainder;
    logic             div_out_valid;

    int checks = 0;
    int errors = 0;

    div_ctrl #(.TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_w(req_w),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag), .flush(flush),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_tag(resp_tag),
        .div_valid(div_valid), .div_sign(div_sign), .div_w(div_w),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_quotient(div_quotient), .div_remainder(div_remainder), .div_out_valid(div_out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- divider model ----------------
    int          dcnt;
    logic        model_ov;
    logic [63:0] pend_q, pend_r, mq, mr;
    logic        spur_vld;

    assign div_out_valid = model_ov | spur_vld;
    assign div_quotient  = spur_vld ? 64'h5A5A_1234_DEAD_BEEF : mq;
    assign div_remainder = spur_vld ? 64'hA5A5_4321_FEED_F00D : mr;

    // Divider core behaviour; special operand pairs return junk so the controller must fix them up.
    function automatic void hw_div(input logic [63:0] a, input logic [63:0] b, input logic s,
                                   input logic dw, output logic [63:0] q, output logic [63:0] r);
        logic [63:0] x;
        logic [63:0] y;
        x = dw ? {{32{a[31]}}, a[31:0]} : a;
        y = dw ? {{32{b[31]}}, b[31:0]} : b;
        if (y == 64'd0) begin
            q = 64'h0BAD_0BAD_0BAD_0BAD;
            r = 64'h0DEF_0DEF_0DEF_0DEF;
        end else if (s && x == 64'h8000_0000_0000_0000 && y == 64'hFFFF_FFFF_FFFF_FFFF) begin
            q = 64'h1111_2222_3333_4444;
            r = 64'h5555_6666_7777_8888;
        end else if (s) begin
            q = $signed(x) / $signed(y);
            r = $signed(x) % $signed(y);
        end else begin
            q = x / y;
            r = x % y;
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic [63:0] hq, hr;
        if (!rst_n) begin
            dcnt <= 0; model_ov <= 1'b0; mq <= 64'd0; mr <= 64'd0;
            pend_q <= 64'd0; pend_r <= 64'd0;
        end else begin
            model_ov <= 1'b0;
            if (dcnt != 0) begin
                dcnt <= dcnt - 1;
                if (dcnt == 1) begin
                    model_ov <= 1'b1; mq <= pend_q; mr <= pend_r;
                end
            end
            if (div_valid) begin
                hw_div(div_dividend, div_divisor, div_sign, div_w, hq, hr);
                pend_q <= hq; pend_r <= hr; dcnt <= 64;
            end
        end
    end

    // Start-pulse monitor: counts cycles with div_valid and records the presented operands.
    int          pulses = 0;
    logic [63:0] cap_a, cap_b;
    logic        cap_s, cap_w;
    always @(posedge clk) begin
        if (rst_n && div_valid) begin
            pulses = pulses + 1;
            cap_a = div_dividend; cap_b = div_divisor; cap_s = div_sign; cap_w = div_w;
        end
    end

    // ---------------- reference model ----------------
    function automatic bit ref_special(input logic [1:0] op, input logic w,
                                       input logic [63:0] a, input logic [63:0] b);
        if (w)
            return (b[31:0] == 0) || (!op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
        return (b == 0) || (!op[0] && a == 64'h8000_0000_0000_0000 && b == '1);
    endfunction

    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic w,
                                               input logic [63:0] a, input logic [63:0] b);
        bit sgn;
        bit rem;
        logic [31:0] q32, r32, s32, a32, b32;
        logic [63:0] q64, r64;
        sgn = !op[0];
        rem = op[1];
        if (w) begin
            a32 = a[31:0];
            b32 = b[31:0];
            if (b32 == 0) begin q32 = '1; r32 = a32; end
            else if (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin q32 = a32; r32 = 0; end
            else if (sgn) begin q32 = $signed(a32) / $signed(b32); r32 = $signed(a32) % $signed(b32); end
            else begin q32 = a32 / b32; r32 = a32 % b32; end
            s32 = rem ? r32 : q32;
            return {{32{s32[31]}}, s32};
        end
        if (b == 0) begin q64 = '1; r64 = a; end
        else if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) begin q64 = a; r64 = 0; end
        else if (sgn) begin q64 = $signed(a) / $signed(b); r64 = $signed(a) % $signed(b); end
        else begin q64 = a / b; r64 = a % b; end
        return rem ? r64 : q64;
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_req_ready"},    {63'd0, req_ready}, 64'd1);
        chk({p, "_resp_valid"},   {63'd0, resp_valid}, 64'd0);
        chk({p, "_resp_data"},    resp_data, 64'd0);
        chk({p, "_resp_tag"},     {59'd0, resp_tag}, 64'd0);
        chk({p, "_div_valid"},    {63'd0, div_valid}, 64'd0);
        chk({p, "_div_sign_w"},   {62'd0, div_sign, div_w}, 64'd0);
        chk({p, "_div_operands"}, div_dividend | div_divisor, 64'd0);
    endtask

    // Presents one request at a falling edge and returns #1 after the accepting rising edge.
    task automatic issue(input logic [1:0] op, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [TAG_W-1:0] tag);
        @(negedge clk);
        chk("req_ready_before_issue", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1; req_op = op; req_w = w; req_a = a; req_b = b; req_tag = tag;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic run_op(input string nm, input logic [1:0] op, input logic w,
                          input logic [63:0] a, input logic [63:0] b, input logic [TAG_W-1:0] tag,
                          input logic [63:0] exp, input int stall, input bit kill);
        int p0, lat, exp_lat, bad;
        bit special;
        logic [63:0] d0;
        special = ref_special(op, w, a, b);
        exp_lat = 67;
`ifdef DIV_FASTPATH_EN
        if (special) exp_lat = 1;
`endif
        p0 = pulses;
        issue(op, w, a, b, tag);
        lat = 1;
        while (!resp_valid && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({nm, "_data"}, resp_data, exp);
        chk({nm, "_tag"}, {59'd0, resp_tag}, {59'd0, tag});
        chk({nm, "_pulses"}, 64'(pulses - p0), (exp_lat == 1) ? 64'd0 : 64'd1);
        if (pulses - p0 == 1) begin
            chk({nm, "_div_a"}, cap_a, (w && op[0]) ? {32'd0, a[31:0]} : a);
            chk({nm, "_div_b"}, cap_b, (w && op[0]) ? {32'd0, b[31:0]} : b);
            chk({nm, "_div_mode"}, {62'd0, cap_s, cap_w}, {62'd0, !op[0], w & !op[0]});
        end
        if (stall > 0) begin
            bad = 0;
            d0 = resp_data;
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                spur_vld = (i == 5);
                if (!resp_valid || resp_data !== d0 || req_ready) bad++;
            end
            @(negedge clk);
            spur_vld = 1'b0;
            if (!resp_valid || resp_data !== d0) bad++;
            chk({nm, "_stall_stable"}, 64'(bad), 64'd0);
        end
        @(negedge clk);
        if (kill) flush = 1'b1; else resp_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; resp_ready = 1'b0;
        chk({nm, "_back_idle"}, {62'd0, req_ready, resp_valid}, 64'd2);
    endtask

    // After a flush of a started divide: no response, no new request until the divider finishes.
    task automatic drain_check(input string nm);
        bit seen, early, bad;
        int n;
        seen = 0; early = 0; bad = 0; n = 0;
        while (!req_ready && n < 300) begin
            @(negedge clk);
            n++;
            if (resp_valid) bad = 1;
            if (req_ready && !seen) early = 1;
            if (div_out_valid) seen = 1;
        end
        chk({nm, "_done_seen"}, {63'd0, seen}, 64'd1);
        chk({nm, "_ready_early"}, {63'd0, early}, 64'd0);
        chk({nm, "_no_resp"}, {63'd0, bad}, 64'd0);
        chk({nm, "_ready"}, {63'd0, req_ready}, 64'd1);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic        w;
        logic [63:0] a;
        logic [63:0] b;
        logic [4:0]  tag;
        logic [63:0] exp;
    } vec_t;

    vec_t tbl[12];

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        logic [1:0]  rop;
        logic        rw;
        logic [63:0] ra, rb;
        logic [4:0]  rtag;

        tbl[0]  = '{2'b01, 1'b0, 64'd100, 64'd7, 5'd3, 64'd14};
        tbl[1]  = '{2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd4, 64'hFFFF_FFFF_FFFF_FFFF};
        tbl[2]  = '{2'b00, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd5, 64'hFFFF_FFFF_8000_0000};
        tbl[3]  = '{2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 5'd6, 64'hFFFF_FFFF_FFFF_FFFF};
        tbl[4]  = '{2'b11, 1'b1, 64'h0000_0001_8000_0001, 64'h0000_0001_0000_0000, 5'd7, 64'hFFFF_FFFF_8000_0001};
        tbl[5]  = '{2'b00, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd8, 64'h8000_0000_0000_0000};
        tbl[6]  = '{2'b10, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd9, 64'd0};
        tbl[7]  = '{2'b10, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_0000_0000, 5'd10, 64'hFFFF_FFFF_9ABC_DEF0};
        tbl[8]  = '{2'b01, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'hABCD_0000_0000_0002, 5'd11, 64'h0000_0000_7FFF_FFFF};
        tbl[9]  = '{2'b00, 1'b1, 64'h0000_0000_FFFF_FFEC, 64'd3, 5'd12, 64'hFFFF_FFFF_FFFF_FFFA};
        tbl[10] = '{2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd10, 5'd13, 64'd5};
        tbl[11] = '{2'b01, 1'b0, 64'd5, 64'd0, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF};

        rst_n = 1'b0; req_valid = 1'b0; req_op = 2'd0; req_w = 1'b0; req_a = 64'd0; req_b = 64'd0;
        req_tag = '0; flush = 1'b0; resp_ready = 1'b0; spur_vld = 1'b0;
        #23;
        chk_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++)
            run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].w, tbl[i].a, tbl[i].b, tbl[i].tag,
                   tbl[i].exp, 0, 1'b0);

        // flush with a request in IDLE: not accepted; stray completion pulse in IDLE ignored
        p0 = pulses;
        @(negedge clk);
        req_valid = 1'b1; flush = 1'b1; req_op = 2'b01; req_w = 1'b0; req_a = 64'd50; req_b = 64'd5;
        @(posedge clk); #1;
        req_valid = 1'b0; flush = 1'b0;
        chk("flush_idle_ready", {63'd0, req_ready}, 64'd1);
        @(negedge clk); spur_vld = 1'b1;
        @(negedge clk); spur_vld = 1'b0;
        chk("flush_idle_state", {62'd0, req_ready, resp_valid}, 64'd2);
        chk("flush_idle_pulses", 64'(pulses - p0), 64'd0);

        // flush 10 cycles into WAIT, then a fresh request
        issue(2'b01, 1'b0, 64'd1000, 64'd3, 5'd7);
        repeat (11) @(posedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        drain_check("flush_wait");
        run_op("after_flush", 2'b01, 1'b0, 64'd9, 64'd3, 5'd2, 64'd3, 0, 1'b0);

        // flush during ISSUE: the start pulse still goes out and must be drained
        p0 = pulses;
        issue(2'b00, 1'b0, 64'd77, 64'd7, 5'd9);
        flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        chk("flush_issue_pulses", 64'(pulses - p0), 64'd1);
        drain_check("flush_issue");

        // flush in RESP drops the result without a handshake
        run_op("flush_resp", 2'b10, 1'b0, 64'd100, 64'd7, 5'd14, 64'd2, 0, 1'b1);

        // writeback stall for 20 cycles with a stray completion pulse in the middle
        run_op("stall", 2'b00, 1'b1, 64'h0000_0000_0000_0064, 64'hFFFF_FFFF_FFFF_FFF9, 5'd21,
               64'hFFFF_FFFF_FFFF_FFF2, 20, 1'b0);

        // reset asserted mid-WAIT
        issue(2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd3, 5'd19);
        repeat (20) @(posedge clk);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk_reset("mid_reset");
        @(negedge clk); rst_n = 1'b1;
        run_op("post_reset", 2'b01, 1'b0, 64'd9, 64'd3, 5'd1, 64'd3, 0, 1'b0);

        // random operations against the reference model
        for (int i = 0; i < 150; i++) begin
            rop = 2'($urandom_range(0, 3));
            rw = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: ra = 64'h8000_0000_0000_0000;
                1: ra = {$urandom(), 32'h8000_0000};
                default: ra = {$urandom(), $urandom()};
            endcase
            case ($urandom_range(0, 6))
                0: rb = 64'd0;
                1: rb = 64'hFFFF_FFFF_FFFF_FFFF;
                2: rb = {$urandom(), 32'h0};
                3: rb = {$urandom(), 32'hFFFF_FFFF};
                4: rb = 64'($urandom_range(1, 20));
                default: rb = {$urandom(), $urandom()};
            endcase
            rtag = 5'($urandom());
            run_op($sformatf("rnd%0d", i), rop, rw, ra, rb, rtag, ref_result(rop, rw, ra, rb), 0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
